load_seq_ctrl: RTL and testbench
================================

LOAD_SEQ_CTRL -- requirements
Module: load_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the max cycles in WAIT/DRAIN before forced completion (legal 1..65535).
REQ-002 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 flush  in  1  synchronous abort of the current operation.
REQ-005 req_valid  in  1  load request from execute stage.
REQ-006 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-007 req_src1  in  64  base operand.
REQ-008 req_src2  in  64  offset operand.
REQ-009 req_flag  in  3  size code: 3'd1 word zero-ext, 3'd2 doubleword, 3'd4 byte zero-ext; others illegal.
REQ-010 mem_req_valid  out  1  memory read request.
REQ-011 mem_req_ready  in  1  memory accepts the request.
REQ-012 mem_addr  out  64  read address.
REQ-013 mem_resp_valid  in  1  read data valid; the controller is always ready for it.
REQ-014 mem_rdata  in  64  read data, already aligned to mem_addr (byte 0 at [7:0]).
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  consumer takes the result.
REQ-017 res_data  out  64  extended load result.
REQ-018 res_err  out  1  illegal flag or timeout.
REQ-019 busy  out  1  high whenever state != IDLE.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, RESP, DRAIN.
REQ-021 req_ready SHALL be 1 only in IDLE with flush=0 and rst_n=1.
REQ-022 On acceptance, the block SHALL latch addr = req_src1 + req_src2 (64-bit, carry discarded) and latch req_flag.
REQ-023 IDLE with a legal flag on acceptance: next state REQ. Illegal flag: next state RESP with res_data=0, res_err=1, no memory access.
REQ-024 REQ: mem_req_valid=1, mem_addr held stable until mem_req_ready; on mem_req_ready, next state WAIT and timer cleared to 0.
REQ-025 WAIT: on mem_resp_valid, res_data SHALL capture the extended data, res_err=0, next state RESP.
REQ-026 Extension: flag1 gives {32'b0, rdata[31:0]}; flag2 gives rdata; flag4 gives {56'b0, rdata[7:0]}.
REQ-027 WAIT timer SHALL increment every cycle. On reaching TIMEOUT_CYCLES without a response: next state RESP, res_data=0, res_err=1.
REQ-028 If mem_resp_valid arrives in the same cycle the timeout fires, the response SHALL win (res_err=0).
REQ-029 RESP: res_valid=1; res_data and res_err SHALL be stable until res_ready; on res_ready, next state IDLE.
REQ-030 A new request SHALL NOT be accepted in the cycle that RESP completes.
REQ-031 Minimum latency: accept at cycle 0, mem_req_valid at 1, resp at 2 at the earliest, res_valid at 3.
REQ-032 mem_resp_valid outside WAIT/DRAIN SHALL be ignored.
REQ-033 flush in IDLE, REQ or RESP: next state IDLE, res_valid=0 next cycle, result discarded.
REQ-034 flush in REQ while mem_req_ready=1 counts as issued: next state DRAIN.
REQ-035 flush in WAIT: next state DRAIN, timer kept running.
REQ-036 DRAIN: the first mem_resp_valid SHALL be discarded, or the timer SHALL reach TIMEOUT_CYCLES; either way, next state IDLE with no result produced.
REQ-037 flush in DRAIN SHALL have no additional effect.
REQ-038 flush=1 together with req_valid=1 in IDLE: the request SHALL NOT be accepted.
REQ-039 At most one memory request SHALL be outstanding at any time.

Reset
REQ-040 While rst_n=0 (asynchronously): state IDLE, timer 0, mem_req_valid=0, mem_addr=0, res_valid=0, res_data=0, res_err=0, busy=0, req_ready=0.
REQ-041 Reset mid-operation SHALL abandon the operation with no drain; the first cycle after release SHALL be IDLE with req_ready=1.

Verification
REQ-042 src1=0x8000_0000, src2=0x10, flag=1, mem_rdata=0xDEAD_BEEF_1234_5678 after 1 cycle -> mem_addr=0x8000_0010, res_data=0x1234_5678, res_err=0, res_valid at cycle 3.
REQ-043 flag=4, rdata=0xFFFF_FFFF_FFFF_FF9A -> res_data=0x9A. flag=2 -> full 64-bit value. src1=0xFFFF_FFFF_FFFF_FFFF, src2=2 -> mem_addr=0x1.
REQ-044 flag=3 -> no mem_req_valid, res_valid next cycle with res_data=0, res_err=1.
REQ-045 TIMEOUT_CYCLES=4, no response -> res_err=1 after 4 WAIT cycles. Response in the timeout cycle -> res_err=0 with data.
REQ-046 flush in WAIT, then response 2 cycles later -> no res_valid, DRAIN then IDLE; the next request completes correctly.
REQ-047 res_ready held 0 for 5 cycles -> res_valid and res_data stable, req_ready=0 throughout. rst_n pulsed low in WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/load_seq_ctrl.sv
// load_seq_ctrl: sequences a single load from the execute stage.
// A request supplies base/offset/size; the controller computes the address,
// issues one memory read, extends the returned data to 64 bits and hands the
// result to the consumer. Flush aborts the current load. A read that is
// already issued is drained so that at most one read is ever outstanding.
// A per-load timer bounds how long the controller waits for a response.
//
// Handshake rule on every port pair (req, mem_req, res): a transfer happens
// in a cycle where valid and ready are both high at the rising edge. Once the
// source raises valid, its payload stays stable until that transfer (or a
// flush/reset abandons it). mem_resp_valid has no ready: it is always taken.

module load_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  input  logic [2:0]  req_flag,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        res_err,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // Size codes
  localparam logic [2:0] F_WORD  = 3'd1;
  localparam logic [2:0] F_DWORD = 3'd2;
  localparam logic [2:0] F_BYTE  = 3'd4;

  // The timer counts completed WAIT/DRAIN cycles; the timeout fires in the
  // cycle where the count is about to reach TIMEOUT_CYCLES.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] timer;
  logic [15:0] timer_nxt;
  logic [2:0]  flag_q;
  logic        accept;
  logic        flag_legal;
  logic        timer_done;
  logic [63:0] ext_data;

  assign accept     = req_valid && req_ready;
  assign timer_done = (timer == TIMER_LAST);

  // Only the three documented size codes start a memory access
  always_comb begin
    flag_legal = 1'b0;
    case (req_flag)
      F_WORD, F_DWORD, F_BYTE: flag_legal = 1'b1;
      default:                 flag_legal = 1'b0;
    endcase
  end

  // Zero-extend the aligned read data according to the latched size code
  always_comb begin
    ext_data = 64'd0;
    case (flag_q)
      F_WORD:  ext_data = {32'd0, mem_rdata[31:0]};
      F_DWORD: ext_data = mem_rdata;
      F_BYTE:  ext_data = {56'd0, mem_rdata[7:0]};
      default: ext_data = 64'd0;
    endcase
  end

  // Next-state and timer logic
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      S_IDLE: begin
        timer_nxt = 16'd0;
        if (accept) begin
          state_nxt = flag_legal ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        // A read accepted in the same cycle as a flush is already in flight
        // and must be drained; otherwise a flush simply abandons the load.
        if (mem_req_ready) begin
          timer_nxt = 16'd0;
          state_nxt = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush) begin
          // If the response or the timeout lands in the flush cycle there is
          // nothing left to drain, so go straight back to idle.
          if (mem_resp_valid || timer_done) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DRAIN;
            timer_nxt = timer + 16'd1;
          end
        end else if (mem_resp_valid || timer_done) begin
          // Response has priority over a coincident timeout.
          state_nxt = S_RESP;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      S_RESP: begin
        if (flush || res_ready) begin
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Flush has no extra effect here: the read is still outstanding.
        if (mem_resp_valid || timer_done) begin
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        timer_nxt = 16'd0;
      end
    endcase
  end

  // State and timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      timer <= 16'd0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Address and size code are captured once per accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= 64'd0;
      flag_q   <= 3'd0;
    end else if (accept) begin
      mem_addr <= req_src1 + req_src2;
      flag_q   <= req_flag;
    end
  end

  // Result registers: written only when entering RESP, so they hold steady
  // for the whole time res_valid is up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= 64'd0;
      res_err  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (accept && !flag_legal) begin
        res_data <= 64'd0;
        res_err  <= 1'b1;
      end
    end else if (state == S_WAIT && !flush) begin
      if (mem_resp_valid) begin
        res_data <= ext_data;
        res_err  <= 1'b0;
      end else if (timer_done) begin
        res_data <= 64'd0;
        res_err  <= 1'b1;
      end
    end
  end

  // Outputs decoded from state; req_ready also drops during flush and reset
  assign req_ready     = (state == S_IDLE) && !flush && rst_n;
  assign mem_req_valid = (state == S_REQ);
  assign res_valid     = (state == S_RESP);
  assign busy          = (state != S_IDLE);
  assign dbg_state     = state;

  // Address must not move while a read request is waiting for acceptance
  a_addr_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req_valid && !mem_req_ready) |=> (!mem_req_valid || $stable(mem_addr)));

  // Result must not move while waiting for the consumer
  a_res_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (res_valid && !res_ready) |=> (!res_valid || ($stable(res_data) && $stable(res_err))));

  // Only the five defined encodings are ever reached
  a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
    (state <= S_DRAIN));

endmodule

// File: tb/tb_load_seq_ctrl.sv
// Testbench for load_seq_ctrl with a short timeout so that timeout and
// drain corner cases take only a few cycles.

module tb_load_seq_ctrl;

  localparam int TO = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic [2:0]  req_flag;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        res_err;
  logic        busy;
  logic [2:0]  dbg_state;

  load_seq_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_src1       (req_src1),
    .req_src2       (req_src2),
    .req_flag       (req_flag),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_err        (res_err),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // scoreboard counters
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // advance one clock; inputs driven and outputs sampled 2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [63:0] src1;
    logic [63:0] src2;
    logic [2:0]  flag;
    logic [63:0] rdata;
    int          delay;   // WAIT cycle index carrying the response; >= TO means none
    int          hold;    // cycles res_ready stays low in RESP
    logic [63:0] exp_addr;
    logic [63:0] exp_data;
    logic        exp_err;
    logic        exp_mem;
  } vec_t;

  vec_t vecs[9];

  // driver: run one complete load from acceptance to result handoff
  task automatic run_load(input int id, input vec_t v);
    string p;
    p = $sformatf("v%0d", id);
    req_valid = 1'b1;
    req_src1  = v.src1;
    req_src2  = v.src2;
    req_flag  = v.flag;
    #1;
    check({p, "_req_ready"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    req_src1  = $urandom();
    req_src2  = $urandom();
    if (v.exp_mem) begin
      check({p, "_mem_req_valid"}, 64'(mem_req_valid), 64'd1);
      check({p, "_mem_addr"}, mem_addr, v.exp_addr);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      check({p, "_in_wait"}, 64'(dbg_state), 64'(S_WAIT));
      for (int k = 0; k < TO; k++) begin
        if (k == v.delay) begin
          mem_resp_valid = 1'b1;
          mem_rdata      = v.rdata;
        end
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = {$urandom(), $urandom()};
        if (k == v.delay) break;
        if (k < TO - 1) check({p, "_wait_no_res"}, 64'(res_valid), 64'd0);
      end
    end else begin
      check({p, "_no_mem_req"}, 64'(mem_req_valid), 64'd0);
    end
    check({p, "_res_valid"}, 64'(res_valid), 64'd1);
    check({p, "_res_data"}, res_data, v.exp_data);
    check({p, "_res_err"}, 64'(res_err), 64'(v.exp_err));
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1'b1;
      #1;
      check({p, "_hold_req_ready"}, 64'(req_ready), 64'd0);
      check({p, "_hold_res_valid"}, 64'(res_valid), 64'd1);
      check({p, "_hold_res_data"}, res_data, v.exp_data);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({p, "_done_res_valid"}, 64'(res_valid), 64'd0);
    check({p, "_done_not_busy"}, 64'(busy), 64'd0);
    req_valid = 1'b0;
    #1;
    check({p, "_idle_req_ready"}, 64'(req_ready), 64'd1);
  endtask

  // driver: accept a legal load and move it into WAIT
  task automatic to_wait(input logic [63:0] src1);
    req_valid = 1'b1;
    req_src1  = src1;
    req_src2  = 64'd0;
    req_flag  = 3'd2;
    tick();
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{64'h8000_0000, 64'h10, 3'd1, 64'hDEAD_BEEF_1234_5678, 0, 0,
                64'h8000_0010, 64'h1234_5678, 1'b0, 1'b1};
    vecs[1] = '{64'h1000, 64'h20, 3'd4, 64'hFFFF_FFFF_FFFF_FF9A, 1, 5,
                64'h1020, 64'h9A, 1'b0, 1'b1};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 3'd2, 64'h0123_4567_89AB_CDEF, 0, 0,
                64'h1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1};
    vecs[3] = '{64'h40, 64'h8, 3'd3, 64'hFFFF, 0, 0, 64'h48, 64'h0, 1'b1, 1'b0};
    vecs[4] = '{64'h40, 64'h8, 3'd0, 64'hFFFF, 0, 0, 64'h48, 64'h0, 1'b1, 1'b0};
    vecs[5] = '{64'h40, 64'h8, 3'd7, 64'hFFFF, 0, 2, 64'h48, 64'h0, 1'b1, 1'b0};
    vecs[6] = '{64'h2000, 64'h100, 3'd2, 64'h1111_2222_3333_4444, 9, 0,
                64'h2100, 64'h0, 1'b1, 1'b1};
    vecs[7] = '{64'h3000, 64'h4, 3'd1, 64'hCAFE_F00D_8765_4321, TO - 1, 0,
                64'h3004, 64'h8765_4321, 1'b0, 1'b1};
    vecs[8] = '{64'h0, 64'h7, 3'd4, 64'h0000_0000_0000_0055, 2, 1,
                64'h7, 64'h55, 1'b0, 1'b1};

    flush          = 1'b0;
    req_valid      = 1'b0;
    req_src1       = 64'd0;
    req_src2       = 64'd0;
    req_flag       = 3'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 64'd0;
    res_ready      = 1'b0;

    // reset state
    #2;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_err", 64'(res_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

    // table-driven loads
    for (int i = 0; i < 9; i++) run_load(i, vecs[i]);

    // memory response outside WAIT/DRAIN is ignored
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    check("stray_resp_busy", 64'(busy), 64'd0);
    check("stray_resp_res_valid", 64'(res_valid), 64'd0);

    // flush together with a request in IDLE: not accepted
    flush     = 1'b1;
    req_valid = 1'b1;
    req_flag  = 3'd2;
    #1;
    check("flush_idle_req_ready", 64'(req_ready), 64'd0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_idle_state", 64'(dbg_state), 64'(S_IDLE));

    // flush in WAIT, response two cycles later is drained
    to_wait(64'h500);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_wait_drain", 64'(dbg_state), 64'(S_DRAIN));
    check("flush_wait_no_res", 64'(res_valid), 64'd0);
    tick();
    check("drain_hold", 64'(dbg_state), 64'(S_DRAIN));
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    mem_resp_valid = 1'b0;
    check("drain_done_idle", 64'(dbg_state), 64'(S_IDLE));
    check("drain_done_no_res", 64'(res_valid), 64'd0);
    run_load(100, vecs[0]);

    // flush in REQ without acceptance: straight to IDLE
    req_valid = 1'b1;
    req_flag  = 3'd1;
    tick();
    req_valid = 1'b0;
    check("req_state", 64'(dbg_state), 64'(S_REQ));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_req_idle", 64'(dbg_state), 64'(S_IDLE));
    check("flush_req_no_mem", 64'(mem_req_valid), 64'd0);

    // flush in REQ while accepted: DRAIN, then timeout back to IDLE
    req_valid = 1'b1;
    tick();
    req_valid     = 1'b0;
    flush         = 1'b1;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("flush_req_issued_drain", 64'(dbg_state), 64'(S_DRAIN));
    for (int k = 0; k < TO - 1; k++) begin
      tick();
      flush = 1'b0;
      check($sformatf("drain_timer_%0d", k), 64'(dbg_state), 64'(S_DRAIN));
    end
    tick();
    check("drain_timeout_idle", 64'(dbg_state), 64'(S_IDLE));
    check("drain_timeout_no_res", 64'(res_valid), 64'd0);

    // flush in RESP discards the result
    req_valid = 1'b1;
    req_flag  = 3'd5;
    tick();
    req_valid = 1'b0;
    check("illegal_resp", 64'(res_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_resp_res_valid", 64'(res_valid), 64'd0);
    check("flush_resp_idle", 64'(dbg_state), 64'(S_IDLE));

    // asynchronous reset in WAIT
    run_load(101, vecs[2]);
    to_wait(64'hABC);
    check("pre_rst_wait", 64'(dbg_state), 64'(S_WAIT));
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_state", 64'(dbg_state), 64'(S_IDLE));
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd0);
    check("arst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("arst_mem_addr", mem_addr, 64'd0);
    check("arst_res_valid", 64'(res_valid), 64'd0);
    check("arst_res_data", res_data, 64'd0);
    check("arst_res_err", 64'(res_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_release_idle", 64'(busy), 64'd0);
    check("arst_release_ready", 64'(req_ready), 64'd1);
    run_load(102, vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
